// File: rtl/ila_trigger_seq.sv
// Multi-stage trigger sequencer feeding one bit of the ILA trigger vector.
// Walks an ordered list of masked match conditions, then fires after an optional delay.
module ila_trigger_seq #(
  parameter int TRIGGER_W = 4,
  parameter int STAGES    = 4,
  parameter int CNT_W     = 16,
  parameter int DELAY_W   = 16
) (
  input  logic                          clk_i,
  input  logic                          arst_n_i,
  input  logic                          cke_i,
  input  logic [TRIGGER_W-1:0]          trig_i,
  input  logic                          arm_i,
  input  logic                          disarm_i,
  input  logic [$clog2(STAGES+1)-1:0]   n_stages_i,
  input  logic [STAGES*TRIGGER_W-1:0]   stage_mask_i,
  input  logic [STAGES*TRIGGER_W-1:0]   stage_value_i,
  input  logic [STAGES*CNT_W-1:0]       stage_count_i,
  input  logic [DELAY_W-1:0]            delay_i,
  output logic                          trigger_o,
  output logic                          fire_o,
  output logic [1:0]                    state_o,
  output logic [$clog2(STAGES)-1:0]     stage_o,
  output logic [CNT_W-1:0]              match_cnt_o
);

  localparam int NS_W = $clog2(STAGES + 1);
  localparam int ST_W = $clog2(STAGES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEQ   = 2'd1,
    DELAY = 2'd2,
    FIRED = 2'd3
  } state_t;

  state_t                      state;
  logic [ST_W-1:0]             stage;
  logic [CNT_W-1:0]            match_cnt;
  logic [DELAY_W-1:0]          delay_cnt;
  logic                        fire_q;

  logic [NS_W-1:0]             sh_n;
  logic [STAGES*TRIGGER_W-1:0] sh_mask;
  logic [STAGES*TRIGGER_W-1:0] sh_value;
  logic [STAGES*CNT_W-1:0]     sh_count;
  logic [DELAY_W-1:0]          sh_delay;

  logic [TRIGGER_W-1:0]        cur_mask;
  logic [TRIGGER_W-1:0]        cur_value;
  logic [CNT_W-1:0]            cur_count;
  logic [CNT_W-1:0]            cur_need;
  logic                        match;
  logic                        stage_done;
  logic                        last_stage;
  logic [NS_W-1:0]             n_clamped;

  always_comb begin
    cur_mask   = sh_mask[int'(stage)*TRIGGER_W +: TRIGGER_W];
    cur_value  = sh_value[int'(stage)*TRIGGER_W +: TRIGGER_W];
    cur_count  = sh_count[int'(stage)*CNT_W +: CNT_W];
    // A required count of zero is read as one so a stage can never be skipped.
    cur_need   = (cur_count == '0) ? CNT_W'(1) : cur_count;
    match      = ((trig_i ^ cur_value) & cur_mask) == '0;
    stage_done = match && (({1'b0, match_cnt} + (CNT_W+1)'(1)) >= {1'b0, cur_need});
    last_stage = (int'(stage) + 1) >= int'(sh_n);
    n_clamped  = (int'(n_stages_i) > STAGES) ? NS_W'(STAGES) : n_stages_i;
  end

  // NOTE: every register here, including the shadow config, is a plain flop
  // with async reset so status reads are defined from power-up; there is no
  // RAM-style storage that would need to stay unreset.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state       <= IDLE;
      stage       <= '0;
      match_cnt   <= '0;
      delay_cnt   <= '0;
      fire_q      <= 1'b0;
      sh_n        <= '0;
      sh_mask     <= '0;
      sh_value    <= '0;
      sh_count    <= '0;
      sh_delay    <= '0;
      trigger_o   <= 1'b0;
      fire_o      <= 1'b0;
      state_o     <= 2'd0;
      stage_o     <= '0;
      match_cnt_o <= '0;
    end else if (cke_i) begin
      // NOTE: non-blocking assignments throughout, so the status copies below
      // see the state as it was before this edge, not the value being written.
      trigger_o   <= (state == FIRED);
      fire_o      <= fire_q;
      state_o     <= state;
      stage_o     <= stage;
      match_cnt_o <= (state == SEQ) ? match_cnt : '0;
      fire_q      <= 1'b0;

      if (disarm_i) begin
        state     <= IDLE;
        stage     <= '0;
        match_cnt <= '0;
        delay_cnt <= '0;
      end else if (arm_i) begin
        sh_n      <= n_clamped;
        sh_mask   <= stage_mask_i;
        sh_value  <= stage_value_i;
        sh_count  <= stage_count_i;
        sh_delay  <= delay_i;
        stage     <= '0;
        match_cnt <= '0;
        delay_cnt <= delay_i;
        if (n_clamped != '0) begin
          state <= SEQ;
        end else if (delay_i == '0) begin
          state  <= FIRED;
          fire_q <= 1'b1;
        end else begin
          state <= DELAY;
        end
      end else begin
        unique case (state)
          SEQ: begin
            if (stage_done) begin
              match_cnt <= '0;
              if (!last_stage) begin
                stage <= stage + 1'b1;
              end else if (sh_delay == '0) begin
                state  <= FIRED;
                fire_q <= 1'b1;
              end else begin
                state     <= DELAY;
                delay_cnt <= sh_delay;
              end
            end else if (match && (match_cnt != '1)) begin
              match_cnt <= match_cnt + 1'b1;
            end
          end
          DELAY: begin
            if (delay_cnt <= DELAY_W'(1)) begin
              state  <= FIRED;
              fire_q <= 1'b1;
            end else begin
              delay_cnt <= delay_cnt - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ila_trigger_seq.sv
// Self-checking bench for ila_trigger_seq: directed scenarios with literal
// expectations plus a randomized run against a cycle-level behavioural model.
module tb_ila_trigger_seq;

  localparam int TW = 4;
  localparam int ST = 4;
  localparam int CW = 16;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              cke;
  logic [TW-1:0]     trig;
  logic              arm;
  logic              disarm;
  logic [2:0]        n_stages;
  logic [ST*TW-1:0]  smask;
  logic [ST*TW-1:0]  sval;
  logic [ST*CW-1:0]  scnt;
  logic [DW-1:0]     delay;
  logic              trigger_o;
  logic              fire_o;
  logic [1:0]        state_o;
  logic [1:0]        stage_o;
  logic [CW-1:0]     match_cnt_o;

  ila_trigger_seq #(
    .TRIGGER_W(TW), .STAGES(ST), .CNT_W(CW), .DELAY_W(DW)
  ) dut (
    .clk_i         (clk),
    .arst_n_i      (arst_n),
    .cke_i         (cke),
    .trig_i        (trig),
    .arm_i         (arm),
    .disarm_i      (disarm),
    .n_stages_i    (n_stages),
    .stage_mask_i  (smask),
    .stage_value_i (sval),
    .stage_count_i (scnt),
    .delay_i       (delay),
    .trigger_o     (trigger_o),
    .fire_o        (fire_o),
    .state_o       (state_o),
    .stage_o       (stage_o),
    .match_cnt_o   (match_cnt_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 sequencing, 2 delaying, 3 fired.
  // Delay is tracked as an absolute enabled-edge number at which firing occurs.
  int m_phase, m_stg, m_hits, m_n, m_delay, m_fire_at, m_tick;
  bit m_fire;
  int m_mask [ST];
  int m_val  [ST];
  int m_cnt  [ST];
  int e_state, e_trig, e_fire, e_stage, e_cnt;

  task automatic model_reset();
    m_phase = 0; m_stg = 0; m_hits = 0; m_n = 0; m_delay = 0;
    m_fire_at = 0; m_tick = 0; m_fire = 0;
    for (int k = 0; k < ST; k++) begin
      m_mask[k] = 0; m_val[k] = 0; m_cnt[k] = 0;
    end
    e_state = 0; e_trig = 0; e_fire = 0; e_stage = 0; e_cnt = 0;
  endtask

  task automatic model_complete(input int d);
    if (d == 0) begin
      m_phase = 3;
      m_fire  = 1;
    end else begin
      m_phase   = 2;
      m_fire_at = m_tick + d;
    end
  endtask

  task automatic model_step();
    int need;
    // Outputs after this edge show what the sequencer was before it.
    e_state = m_phase;
    e_trig  = (m_phase == 3) ? 1 : 0;
    e_fire  = m_fire ? 1 : 0;
    e_stage = m_stg;
    e_cnt   = (m_phase == 1) ? m_hits : 0;
    m_fire  = 0;
    m_tick++;
    if (disarm) begin
      m_phase = 0; m_stg = 0; m_hits = 0;
    end else if (arm) begin
      m_n = (int'(n_stages) > ST) ? ST : int'(n_stages);
      for (int k = 0; k < ST; k++) begin
        m_mask[k] = int'(smask[k*TW +: TW]);
        m_val[k]  = int'(sval[k*TW +: TW]);
        m_cnt[k]  = int'(scnt[k*CW +: CW]);
      end
      m_delay = int'(delay);
      m_stg = 0; m_hits = 0;
      if (m_n == 0) model_complete(m_delay);
      else          m_phase = 1;
    end else if (m_phase == 1) begin
      if ((int'(trig) & m_mask[m_stg]) == (m_val[m_stg] & m_mask[m_stg])) begin
        need = (m_cnt[m_stg] == 0) ? 1 : m_cnt[m_stg];
        if (m_hits + 1 >= need) begin
          m_hits = 0;
          if (m_stg == m_n - 1) model_complete(m_delay);
          else                  m_stg++;
        end else begin
          m_hits = (m_hits == 65535) ? 65535 : m_hits + 1;
        end
      end
    end else if (m_phase == 2) begin
      if (m_tick == m_fire_at) begin
        m_phase = 3;
        m_fire  = 1;
      end
    end
  endtask

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n)  model_reset();
    else if (cke) model_step();
  end

  always @(negedge clk) begin
    check("model state_o",     int'(state_o),     e_state);
    check("model trigger_o",   int'(trigger_o),   e_trig);
    check("model fire_o",      int'(fire_o),      e_fire);
    check("model stage_o",     int'(stage_o),     e_stage);
    check("model match_cnt_o", int'(match_cnt_o), e_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cfg();
    smask = '0;
    sval  = '0;
    for (int k = 0; k < ST; k++) scnt[k*CW +: CW] = CW'(1);
    delay    = '0;
    n_stages = '0;
  endtask

  task automatic set_stage(input int k, input int m, input int v, input int c);
    smask[k*TW +: TW] = TW'(m);
    sval[k*TW +: TW]  = TW'(v);
    scnt[k*CW +: CW]  = CW'(c);
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    arst_n = 1'b0; cke = 1'b1; trig = '0; arm = 1'b0; disarm = 1'b0;
    clr_cfg();
    #22 arst_n = 1'b1;
    tick();
    check("reset state_o",     int'(state_o), 0);
    check("reset trigger_o",   int'(trigger_o), 0);
    check("reset fire_o",      int'(fire_o), 0);
    check("reset stage_o",     int'(stage_o), 0);
    check("reset match_cnt_o", int'(match_cnt_o), 0);

    // Async reset in the middle of a sequence.
    clr_cfg(); n_stages = 3'd2;
    set_stage(0, 'h0, 'h0, 1); set_stage(1, 'hF, 'hF, 5);
    arm_pulse();
    trig = '0;
    tick(); tick();
    check("midseq stage_o", int'(stage_o), 1);
    #2 arst_n = 1'b0;
    #1;
    check("async rst state_o",     int'(state_o), 0);
    check("async rst trigger_o",   int'(trigger_o), 0);
    check("async rst fire_o",      int'(fire_o), 0);
    check("async rst stage_o",     int'(stage_o), 0);
    check("async rst match_cnt_o", int'(match_cnt_o), 0);
    @(posedge clk); #3 arst_n = 1'b1;
    tick();
    check("post rst state_o", int'(state_o), 0);

    // Two-stage sequence with non-consecutive occurrences.
    clr_cfg(); n_stages = 3'd2;
    set_stage(0, 'h1, 'h1, 3); set_stage(1, 'h6, 'h4, 1);
    arm_pulse();
    trig = 4'h1; tick();
    trig = 4'h0; tick();
    trig = 4'h1; tick();
    trig = 4'h1; tick();
    check("2stg stage_o before step", int'(stage_o), 0);
    check("2stg match_cnt_o", int'(match_cnt_o), 2);
    trig = 4'h4; tick();
    check("2stg stage_o stepped", int'(stage_o), 1);
    check("2stg trigger_o early", int'(trigger_o), 0);
    trig = 4'h0; tick();
    check("2stg trigger_o", int'(trigger_o), 1);
    check("2stg fire_o", int'(fire_o), 1);
    tick();
    check("2stg fire_o pulse end", int'(fire_o), 0);
    check("2stg trigger_o held", int'(trigger_o), 1);

    // Post-sequence delay of 5.
    clr_cfg(); n_stages = 3'd1; set_stage(0, 'hF, 'hA, 1); delay = 16'd5;
    trig = '0; arm_pulse();
    trig = 4'hA; tick();
    trig = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("delay state_o", int'(state_o), 2);
    end
    tick();
    check("delay trigger_o", int'(trigger_o), 1);
    check("delay fire_o", int'(fire_o), 1);

    // Zero stages, zero delay.
    disarm = 1'b1; tick(); disarm = 1'b0; tick();
    check("disarm state_o", int'(state_o), 0);
    check("disarm trigger_o", int'(trigger_o), 0);
    clr_cfg(); arm_pulse(); tick();
    check("n0 trigger_o", int'(trigger_o), 1);
    check("n0 fire_o", int'(fire_o), 1);

    // Count 0 behaves as 1.
    clr_cfg(); n_stages = 3'd1; set_stage(0, 'hF, 'h3, 0);
    arm_pulse();
    trig = 4'h3; tick();
    trig = 4'h0; tick();
    check("cnt0 trigger_o", int'(trigger_o), 1);
    check("cnt0 fire_o", int'(fire_o), 1);

    // n_stages beyond STAGES is clamped.
    clr_cfg(); n_stages = 3'd7;
    arm_pulse();
    trig = 4'h9;
    repeat (4) tick();
    check("clamp stage_o", int'(stage_o), 3);
    check("clamp trigger_o early", int'(trigger_o), 0);
    tick();
    check("clamp trigger_o", int'(trigger_o), 1);

    // Simultaneous arm and disarm.
    trig = '0;
    arm = 1'b1; disarm = 1'b1; tick(); arm = 1'b0; disarm = 1'b0; tick();
    check("arm+disarm state_o", int'(state_o), 0);
    check("arm+disarm trigger_o", int'(trigger_o), 0);

    // Config changes after arm are ignored.
    clr_cfg(); n_stages = 3'd1; set_stage(0, 'hF, 'h5, 2);
    arm_pulse();
    set_stage(0, 'hF, 'hA, 2);
    trig = 4'hA; tick(); tick();
    check("latch match_cnt_o", int'(match_cnt_o), 0);
    check("latch state_o", int'(state_o), 1);
    trig = 4'h5; tick(); tick();
    check("latch match_cnt_o counted", int'(match_cnt_o), 1);
    trig = 4'h0; tick();
    check("latch trigger_o", int'(trigger_o), 1);

    // Re-arm from FIRED.
    arm_pulse(); tick();
    check("rearm trigger_o", int'(trigger_o), 0);
    check("rearm state_o", int'(state_o), 1);

    // Clock enable low during DELAY stretches it.
    clr_cfg(); n_stages = 3'd1; set_stage(0, 'hF, 'hA, 1); delay = 16'd5;
    arm_pulse();
    trig = 4'hA; tick();
    trig = 4'h0; tick(); tick();
    cke = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("cke frozen state_o", int'(state_o), 2);
    end
    cke = 1'b1;
    tick(); tick(); tick();
    check("cke trigger_o early", int'(trigger_o), 0);
    tick();
    check("cke trigger_o", int'(trigger_o), 1);
    check("cke fire_o", int'(fire_o), 1);

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      cke      = ($urandom_range(9) != 0);
      trig     = TW'($urandom);
      arm      = ($urandom_range(59) == 0);
      disarm   = ($urandom_range(199) == 0);
      n_stages = 3'($urandom_range(7));
      for (int k = 0; k < ST; k++)
        set_stage(k, int'($urandom & $urandom) & 'hF, int'($urandom) & 'hF,
                  int'($urandom_range(3)));
      delay = DW'($urandom_range(6));
      tick();
    end
    arm = 1'b0; disarm = 1'b0; cke = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
